// File: rtl/cvxif_pkg.sv
// -----------------------------------------------------------------------------
// cvxif_pkg
// Shared types and defaults for the offload dispatcher (pe_dispatch).
//   state_e  : dispatcher FSM states
//   resp_t   : registered response (id, rd, data, err) returned to the core
//   DEFAULT_TIMEOUT_CYCLES / DEFAULT_ID_WIDTH : parameter defaults
// -----------------------------------------------------------------------------
package cvxif_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int unsigned DEFAULT_ID_WIDTH       = 4;
    // Widest instruction id the response struct can carry.
    localparam int unsigned MAX_ID_WIDTH           = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    typedef struct packed {
        logic [MAX_ID_WIDTH-1:0] id;
        logic [4:0]              rd;
        logic [31:0]             data;
        logic                    err;
    } resp_t;

endpackage

// File: rtl/pe_dispatch_if.sv
// -----------------------------------------------------------------------------
// pe_dispatch_if
// Core-side issue/result channel of the offload dispatcher.
//   issue_*  : core -> dispatcher (valid/ready handshake, id, rd, rs1, rs2)
//   result_* : dispatcher -> core (valid/ready handshake, id, rd, data, err)
// Signal suffixes (_i/_o) are named from the dispatcher's point of view.
// Modports: master = core side, slave = dispatcher side.
// -----------------------------------------------------------------------------
interface pe_dispatch_if #(
    parameter int unsigned ID_WIDTH = cvxif_pkg::DEFAULT_ID_WIDTH
);

    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [4:0]          issue_rd_i;
    logic [31:0]         issue_rs1_i;
    logic [31:0]         issue_rs2_i;

    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [4:0]          result_rd_o;
    logic [31:0]         result_data_o;
    logic                result_err_o;

    modport master (
        output issue_valid_i, issue_id_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        output result_ready_i,
        input  issue_ready_o,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o
    );

    modport slave (
        input  issue_valid_i, issue_id_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
        input  result_ready_i,
        output issue_ready_o,
        output result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o
    );

endinterface

// File: rtl/pe_dispatch.sv
// -----------------------------------------------------------------------------
// pe_dispatch
// Accepts one offload instruction at a time from the core, launches the
// processing element (PE) with the image height/width, waits for it to finish
// (bounded by TIMEOUT_CYCLES) and returns a response to the core.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   core (slave modport)   : issue and result handshakes toward the core
//   pe_start_o             : one-cycle start pulse to the PE
//   pe_height_o/pe_width_o : dimensions captured at the last accepted issue
//   pe_result_i            : PE result, valid while pe_finished_i is high
//   pe_finished_i          : PE done (only observed while waiting)
//   busy_o                 : high whenever the dispatcher is not idle
// -----------------------------------------------------------------------------
module pe_dispatch
    import cvxif_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned ID_WIDTH       = DEFAULT_ID_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    pe_dispatch_if.slave core,
    output logic         pe_start_o,
    output logic [15:0]  pe_height_o,
    output logic [15:0]  pe_width_o,
    input  logic [31:0]  pe_result_i,
    input  logic         pe_finished_i,
    output logic         busy_o
);

    localparam int unsigned      CntW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    resp_t           r_resp, w_resp_next;
    logic [15:0]     r_height, w_height_next;
    logic [15:0]     r_width, w_width_next;

    // Only the low halves of the operands carry dimensions.
    logic w_unused_operand;
    assign w_unused_operand = ^{core.issue_rs1_i[31:16], core.issue_rs2_i[31:16]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_resp   <= '0;
            r_height <= '0;
            r_width  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_resp   <= w_resp_next;
            r_height <= w_height_next;
            r_width  <= w_width_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_resp_next   = r_resp;
        w_height_next = r_height;
        w_width_next  = r_width;

        unique case (r_state)
            StIdle: begin
                if (core.issue_valid_i) begin
                    w_resp_next.id   = MAX_ID_WIDTH'(core.issue_id_i);
                    w_resp_next.rd   = core.issue_rd_i;
                    w_resp_next.data = '0;
                    w_height_next    = core.issue_rs1_i[15:0];
                    w_width_next     = core.issue_rs2_i[15:0];
                    if ((core.issue_rs1_i[15:0] != 16'd0) && (core.issue_rs2_i[15:0] != 16'd0)) begin
                        w_resp_next.err = 1'b0;
                        w_state_next    = StStart;
                    end else begin
                        // Degenerate image: answer with an error, never start the PE.
                        w_resp_next.err = 1'b1;
                        w_state_next    = StResp;
                    end
                end
            end
            StStart: begin
                w_cnt_next   = '0;
                w_state_next = StWait;
            end
            StWait: begin
                if (r_cnt != '1) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                // Finish wins over a timeout landing in the same cycle.
                if (pe_finished_i) begin
                    w_resp_next.data = pe_result_i;
                    w_resp_next.err  = 1'b0;
                    w_state_next     = StResp;
                end else if (r_cnt == CntLast) begin
                    w_resp_next.data = '0;
                    w_resp_next.err  = 1'b1;
                    w_state_next     = StResp;
                end
            end
            StResp: begin
                if (core.result_ready_i) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign core.issue_ready_o  = (r_state == StIdle);
    assign core.result_valid_o = (r_state == StResp);
    assign core.result_id_o    = ID_WIDTH'(r_resp.id);
    assign core.result_rd_o    = r_resp.rd;
    assign core.result_data_o  = r_resp.data;
    assign core.result_err_o   = r_resp.err;

    assign pe_start_o  = (r_state == StStart);
    assign pe_height_o = r_height;
    assign pe_width_o  = r_width;
    assign busy_o      = (r_state != StIdle);

endmodule
